// File: rtl/tiny86_pkg.sv
// tiny86_pkg: definitions shared by the tiny86 trace tooling.
//   - Layout of a 560-bit trace step (raw instruction, register file, two hints).
//   - Register index constants in compare/bitmap order (bit0 = eax).
//   - Trace sequencer state encoding.
//   - step_reg(): pulls one 32-bit register out of a step's register field.
package tiny86_pkg;

  localparam int STEP_W    = 560;
  localparam int INSTR_MSB = 559;
  localparam int INSTR_LSB = 464;
  localparam int REG_MSB   = 463;  // eax occupies the top slot of the field
  localparam int REG_BASE  = 144;  // eflags occupies the bottom slot
  localparam int HINT1_MSB = 143;
  localparam int HINT1_LSB = 72;
  localparam int HINT2_MSB = 71;
  localparam int HINT2_LSB = 0;

  localparam int REG_W    = 32;
  localparam int NUM_REGS = 10;
  localparam int REGS_W   = REG_W * NUM_REGS;

  localparam int R_EAX    = 0;
  localparam int R_EBX    = 1;
  localparam int R_ECX    = 2;
  localparam int R_EDX    = 3;
  localparam int R_ESI    = 4;
  localparam int R_EDI    = 5;
  localparam int R_ESP    = 6;
  localparam int R_EBP    = 7;
  localparam int R_EIP    = 8;
  localparam int R_EFLAGS = 9;

  typedef logic [2:0] seq_state_t;
  localparam seq_state_t ST_EMPTY  = 3'd0;
  localparam seq_state_t ST_PRIMED = 3'd1;
  localparam seq_state_t ST_EVAL   = 3'd2;
  localparam seq_state_t ST_DONE   = 3'd3;
  localparam seq_state_t ST_FAULT  = 3'd4;

  // Register idx of a step; idx 0 (eax) sits at the MSB end of the field.
  function automatic logic [REG_W-1:0] step_reg(input logic [STEP_W-1:0] s, input int idx);
    return s[REG_MSB - REG_W*idx -: REG_W];
  endfunction

endpackage

// File: rtl/trace_step_sequencer_if.sv
// trace_step_sequencer_if: trace ingress stream (valid/ready handshake).
//   step_in    : 560-bit trace step
//   step_valid : step_in holds a step
//   step_last  : step_in is the final step of the trace
//   step_ready : consumer accepts step_in this cycle
// master = trace source, slave = sequencer.
interface trace_step_sequencer_if;
  logic [tiny86_pkg::STEP_W-1:0] step_in;
  logic                          step_valid;
  logic                          step_last;
  logic                          step_ready;

  modport master (output step_in, output step_valid, output step_last, input step_ready);
  modport slave  (input step_in, input step_valid, input step_last, output step_ready);
endinterface

// File: rtl/trace_step_sequencer_regfile_cmp.sv
// regfile_cmp: combinational masked compare of two 10x32 register bundles.
//   a_regs, b_regs : {eflags,eip,ebp,esp,edi,esi,edx,ecx,ebx,eax}, eax in bits [31:0]
//   diff           : bit i set when register i is enabled in CHECK_MASK and differs
module regfile_cmp
  import tiny86_pkg::*;
#(
  parameter logic [NUM_REGS-1:0] CHECK_MASK = 10'h0FF
) (
  input  logic [REGS_W-1:0]   a_regs,
  input  logic [REGS_W-1:0]   b_regs,
  output logic [NUM_REGS-1:0] diff
);

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
    assign diff[gi] = CHECK_MASK[gi] && (a_regs[REG_W*gi +: REG_W] != b_regs[REG_W*gi +: REG_W]);
  end

endmodule

// File: rtl/trace_step_sequencer.sv
// trace_step_sequencer: feeds trace steps to the tiny86 evaluator one at a time
// and checks each computed post-state against the next recorded step.
//   clk, rst      : clock, synchronous active-high reset
//   ingress       : trace step stream (slave side)
//   eval_step     : step presented to the evaluator (current step)
//   eval_valid    : eval_step holds a live step
//   eval_regs     : evaluator post-state, combinational from eval_step
//   steps_checked : transitions compared and passed (saturating)
//   mismatch      : sticky compare failure
//   mismatch_regs : failing-register bitmap of the first mismatch
//   mismatch_idx  : steps_checked at the first mismatch
//   done, ok      : trace finished / finished without mismatch
module trace_step_sequencer
  import tiny86_pkg::*;
#(
  parameter logic [NUM_REGS-1:0] CHECK_MASK = 10'h0FF,
  parameter int                  CNT_W      = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  trace_step_sequencer_if.slave   ingress,
  output logic [STEP_W-1:0]       eval_step,
  output logic                    eval_valid,
  input  logic [REGS_W-1:0]       eval_regs,
  output logic [CNT_W-1:0]        steps_checked,
  output logic                    mismatch,
  output logic [NUM_REGS-1:0]     mismatch_regs,
  output logic [CNT_W-1:0]        mismatch_idx,
  output logic                    done,
  output logic                    ok
);

  seq_state_t          state_q, state_d;
  logic [STEP_W-1:0]   cur_q, cur_d;
  logic [STEP_W-1:0]   nxt_q, nxt_d;
  logic                last_q, last_d;
  logic                eval_valid_q, eval_valid_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                mismatch_q, mismatch_d;
  logic [NUM_REGS-1:0] mm_regs_q, mm_regs_d;
  logic [CNT_W-1:0]    mm_idx_q, mm_idx_d;
  logic                done_q, done_d;
  logic                ok_q, ok_d;

  logic [REGS_W-1:0]   nxt_regs;
  logic [NUM_REGS-1:0] diff;
  logic                xfer;

  // The step layout stores eax in the top slot while the evaluator bundle
  // keeps eax at the bottom; flip nxt's field into evaluator order.
  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_nxt_reorder
    assign nxt_regs[REG_W*gi +: REG_W] = step_reg(nxt_q, gi);
  end

  regfile_cmp #(.CHECK_MASK(CHECK_MASK)) u_cmp (
    .a_regs (eval_regs),
    .b_regs (nxt_regs),
    .diff   (diff)
  );

  // Ready is held low during reset so nothing can look accepted while the
  // sequencer is being cleared.
  assign ingress.step_ready = !rst && ((state_q == ST_EMPTY) || (state_q == ST_PRIMED));
  assign xfer               = ingress.step_valid && ingress.step_ready;

  always_comb begin
    state_d      = state_q;
    cur_d        = cur_q;
    nxt_d        = nxt_q;
    last_d       = last_q;
    eval_valid_d = eval_valid_q;
    cnt_d        = cnt_q;
    mismatch_d   = mismatch_q;
    mm_regs_d    = mm_regs_q;
    mm_idx_d     = mm_idx_q;
    done_d       = done_q;
    ok_d         = ok_q;

    case (state_q)
      ST_EMPTY: begin
        if (xfer) begin
          cur_d        = ingress.step_in;
          eval_valid_d = 1'b1;
          if (ingress.step_last) begin
            // Single-step trace: no transition to check.
            state_d = ST_DONE;
            done_d  = 1'b1;
            ok_d    = 1'b1;
          end else begin
            state_d = ST_PRIMED;
          end
        end
      end
      ST_PRIMED: begin
        if (xfer) begin
          nxt_d   = ingress.step_in;
          last_d  = ingress.step_last;
          state_d = ST_EVAL;
        end
      end
      ST_EVAL: begin
        if (diff == '0) begin
          if (cnt_q != {CNT_W{1'b1}}) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
          end
          cur_d = nxt_q;
          if (last_q) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            ok_d    = 1'b1;
          end else begin
            state_d = ST_PRIMED;
          end
        end else begin
          // Keep the failing pre-state on eval_step for inspection.
          mismatch_d = 1'b1;
          mm_regs_d  = diff;
          mm_idx_d   = cnt_q;
          state_d    = ST_FAULT;
          done_d     = 1'b1;
          ok_d       = 1'b0;
        end
      end
      default: begin
        // DONE / FAULT are terminal until reset.
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_EMPTY;
      cur_q        <= '0;
      nxt_q        <= '0;
      last_q       <= 1'b0;
      eval_valid_q <= 1'b0;
      cnt_q        <= '0;
      mismatch_q   <= 1'b0;
      mm_regs_q    <= '0;
      mm_idx_q     <= '0;
      done_q       <= 1'b0;
      ok_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_q        <= cur_d;
      nxt_q        <= nxt_d;
      last_q       <= last_d;
      eval_valid_q <= eval_valid_d;
      cnt_q        <= cnt_d;
      mismatch_q   <= mismatch_d;
      mm_regs_q    <= mm_regs_d;
      mm_idx_q     <= mm_idx_d;
      done_q       <= done_d;
      ok_q         <= ok_d;
    end
  end

  assign eval_step     = cur_q;
  assign eval_valid    = eval_valid_q;
  assign steps_checked = cnt_q;
  assign mismatch      = mismatch_q;
  assign mismatch_regs = mm_regs_q;
  assign mismatch_idx  = mm_idx_q;
  assign done          = done_q;
  assign ok            = ok_q;

endmodule

// File: tb/tb_trace_step_sequencer.sv
// Bench for trace_step_sequencer: two instances (default mask and a mask that
// also checks eip) see the same ingress stream; a stub evaluator returns
// eax+1 with all other registers passed through.
module tb_trace_step_sequencer;
  import tiny86_pkg::*;

  localparam logic [9:0] MASK_A = 10'h0FF;
  localparam logic [9:0] MASK_B = 10'h1FF;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  trace_step_sequencer_if if_a();
  trace_step_sequencer_if if_b();

  assign if_b.step_in    = if_a.step_in;
  assign if_b.step_valid = if_a.step_valid;
  assign if_b.step_last  = if_a.step_last;

  logic [559:0] es_a, es_b;
  logic         ev_a, ev_b;
  logic [319:0] er_a, er_b;
  logic [31:0]  sc_a, sc_b, mi_a, mi_b;
  logic         mm_a, mm_b, dn_a, dn_b, ok_a, ok_b;
  logic [9:0]   mr_a, mr_b;

  int n_vec = 0;
  int n_err = 0;
  logic [559:0] tr [0:15];

  function automatic logic [31:0] reg_of(input logic [559:0] s, input int i);
    return s[463 - 32*i -: 32];
  endfunction

  function automatic logic [559:0] set_reg(input logic [559:0] s, input int i, input logic [31:0] v);
    logic [559:0] t;
    t = s;
    t[463 - 32*i -: 32] = v;
    return t;
  endfunction

  // Intended evaluator behaviour: eax increments, everything else unchanged.
  function automatic logic [319:0] stub_eval(input logic [559:0] s);
    logic [319:0] r;
    for (int i = 0; i < 10; i++) r[32*i +: 32] = (i == 0) ? reg_of(s, 0) + 32'd1 : reg_of(s, i);
    return r;
  endfunction

  function automatic logic [559:0] rand_step();
    logic [575:0] t;
    for (int w = 0; w < 18; w++) t[32*w +: 32] = $urandom;
    return t[559:0];
  endfunction

  assign er_a = stub_eval(es_a);
  assign er_b = stub_eval(es_b);

  trace_step_sequencer #(.CHECK_MASK(MASK_A), .CNT_W(32)) u_dut_a (
    .clk(clk), .rst(rst), .ingress(if_a), .eval_step(es_a), .eval_valid(ev_a),
    .eval_regs(er_a), .steps_checked(sc_a), .mismatch(mm_a), .mismatch_regs(mr_a),
    .mismatch_idx(mi_a), .done(dn_a), .ok(ok_a));

  trace_step_sequencer #(.CHECK_MASK(MASK_B), .CNT_W(32)) u_dut_b (
    .clk(clk), .rst(rst), .ingress(if_b), .eval_step(es_b), .eval_valid(ev_b),
    .eval_regs(er_b), .steps_checked(sc_b), .mismatch(mm_b), .mismatch_regs(mr_b),
    .mismatch_idx(mi_b), .done(dn_b), .ok(ok_b));

  task automatic chk(input string tag, input logic [559:0] got, input logic [559:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called while rst is still high.
  task automatic chk_reset(input string tag);
    chk({tag, "_a_ready"}, if_a.step_ready, 0);
    chk({tag, "_a_checked"}, sc_a, 0);
    chk({tag, "_a_mismatch"}, mm_a, 0);
    chk({tag, "_a_mregs"}, mr_a, 0);
    chk({tag, "_a_midx"}, mi_a, 0);
    chk({tag, "_a_done"}, dn_a, 0);
    chk({tag, "_a_ok"}, ok_a, 0);
    chk({tag, "_a_evalid"}, ev_a, 0);
    chk({tag, "_a_estep"}, es_a, 0);
    chk({tag, "_b_mismatch"}, mm_b, 0);
    chk({tag, "_b_estep"}, es_b, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    if_a.step_valid = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    chk_reset("reset");
    rst = 1'b0;
    @(posedge clk); #1;
    chk("reset_a_ready_after", if_a.step_ready, 1);
  endtask

  // n steps; if 1 <= c < n, step c has register r corrupted relative to what
  // the evaluator derives from step c-1.
  task automatic build_trace(input int n, input int c, input int r);
    logic [559:0] s;
    logic [319:0] post;
    for (int k = 0; k < n; k++) begin
      s = rand_step();
      if (k > 0) begin
        post = stub_eval(tr[k-1]);
        for (int i = 0; i < 10; i++) s = set_reg(s, i, post[32*i +: 32]);
      end
      if (c >= 1 && k == c) s = set_reg(s, r, reg_of(s, r) ^ ($urandom | 32'd1));
      tr[k] = s;
    end
  endtask

  task automatic run_trace(input int n, input int c, input int r, input bit rand_valid,
                           input bit abort_eval, input string name);
    int idx = 0;
    int cyc = 0;
    int chk_t = 0;
    bit chk_e = 0;
    bit chk_p = 0;
    bit fa, fb, v, x;
    fa = (c >= 1) && (c < n) && MASK_A[r];
    fb = (c >= 1) && (c < n) && MASK_B[r];
    build_trace(n, c, r);
    while (1) begin
      if (chk_e) begin
        if (abort_eval) begin
          rst = 1'b1;
          if_a.step_valid = 1'b0;
          @(posedge clk); #1;
          chk_reset({name, "_abort"});
          rst = 1'b0;
          @(posedge clk); #1;
          chk({name, "_abort_ready"}, if_a.step_ready, 1);
          $display("trace %s: n=%0d aborted in EVAL", name, n);
          return;
        end
        chk({name, "_rdy_eval"}, if_a.step_ready, 0);
        chk_e = 0;
        if (chk_t < n - 1 && !(fa && chk_t == c)) chk_p = 1;
      end else if (chk_p) begin
        chk({name, "_rdy_primed"}, if_a.step_ready, 1);
        chk_p = 0;
      end
      if ((idx == n || (fa && idx > c)) && !chk_e && !chk_p) break;
      if (cyc++ > 200) begin
        n_vec++; n_err++;
        $display("FAIL %s_timeout: got idx %0d expected %0d", name, idx, n);
        break;
      end
      v = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
      if (v && idx < n) begin
        if_a.step_in   = tr[idx];
        if_a.step_last = (idx == n - 1);
      end else begin
        if_a.step_in   = rand_step();
        if_a.step_last = 1'($urandom_range(0, 1));
      end
      if_a.step_valid = v;
      x = v && (idx < n) && if_a.step_ready;
      @(posedge clk); #1;
      if (x) begin
        if (idx >= 1) begin chk_e = 1; chk_t = idx; end
        idx++;
      end
    end
    // Terminal states must ignore further traffic.
    for (int k = 0; k < 3; k++) begin
      if_a.step_in = rand_step();
      if_a.step_last = 1'($urandom_range(0, 1));
      if_a.step_valid = 1'b1;
      @(posedge clk); #1;
    end
    if_a.step_valid = 1'b0;
    chk({name, "_a_checked"}, sc_a, fa ? c - 1 : n - 1);
    chk({name, "_a_mismatch"}, mm_a, fa);
    chk({name, "_a_mregs"}, mr_a, fa ? (10'd1 << r) : 10'd0);
    chk({name, "_a_midx"}, mi_a, fa ? c - 1 : 0);
    chk({name, "_a_done"}, dn_a, 1);
    chk({name, "_a_ok"}, ok_a, !fa);
    chk({name, "_a_ready"}, if_a.step_ready, 0);
    chk({name, "_a_evalid"}, ev_a, 1);
    chk({name, "_a_estep"}, es_a, fa ? tr[c-1] : tr[n-1]);
    chk({name, "_b_checked"}, sc_b, fb ? c - 1 : n - 1);
    chk({name, "_b_mismatch"}, mm_b, fb);
    chk({name, "_b_mregs"}, mr_b, fb ? (10'd1 << r) : 10'd0);
    chk({name, "_b_midx"}, mi_b, fb ? c - 1 : 0);
    chk({name, "_b_ok"}, ok_b, !fb);
    chk({name, "_b_ready"}, if_b.step_ready, 0);
    chk({name, "_b_estep"}, es_b, fb ? tr[c-1] : tr[n-1]);
    $display("trace %s: n=%0d corrupt_step=%0d reg=%0d checked_a=%0d mregs_a=%03h mregs_b=%03h",
             name, n, c, r, sc_a, mr_a, mr_b);
  endtask

  initial begin
    int n, c, r;
    rst = 1'b1;
    if_a.step_in = '0;
    if_a.step_valid = 1'b0;
    if_a.step_last = 1'b0;
    do_reset();
    run_trace(3, 0, 0, 1'b0, 1'b0, "pass3");
    do_reset();
    run_trace(3, 1, R_EBX, 1'b0, 1'b0, "ebx_fault");
    do_reset();
    run_trace(3, 2, R_EIP, 1'b0, 1'b0, "eip_diff");
    do_reset();
    run_trace(1, 0, 0, 1'b0, 1'b0, "single");
    do_reset();
    run_trace(3, 1, R_EBX, 1'b0, 1'b1, "abort");
    run_trace(2, 0, 0, 1'b1, 1'b0, "after_abort");
    for (int t = 0; t < 10; t++) begin
      do_reset();
      n = $urandom_range(1, 8);
      c = $urandom_range(0, n - 1);
      r = $urandom_range(0, 9);
      run_trace(n, c, r, 1'b1, 1'b0, "rand");
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
